// File: rtl/inst_sequencer.sv
// rtl/inst_sequencer.sv - walks loaded instruction memory and issues repeat-expanded beats to the core array
module inst_sequencer #(
    parameter int INST_BW   = 17,
    parameter int DEPTH_LOG = 4,
    parameter int MEM_AW    = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_ex,
    input  logic [DEPTH_LOG:0]   inst_count,
    input  logic [MEM_AW-1:0]    mem_base,
    output logic                 rd_en,
    output logic [DEPTH_LOG-1:0] rd_addr,
    input  logic [INST_BW-1:0]   rd_data,
    output logic [INST_BW-1:0]   inst_out,
    output logic                 inst_valid,
    input  logic                 core_ready,
    output logic [MEM_AW-1:0]    mem_addr,
    output logic                 busy,
    output logic                 done
);

    localparam int HALT_BIT = INST_BW - 1;
    localparam int REP_HI   = INST_BW - 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [DEPTH_LOG-1:0] pc;
    logic [DEPTH_LOG:0]   count_q;
    logic [3:0]           rep_cnt;
    logic                 beat;
    logic                 last_inst;

    assign beat      = (state == S_ISSUE) && core_ready;
    // Compare one bit wider so a full 16-entry buffer terminates while pc itself wraps to 0.
    assign last_inst = (({1'b0, pc} + {{DEPTH_LOG{1'b0}}, 1'b1}) == count_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_ex) begin
                    state_nxt = (inst_count == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH:   state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = rd_data[HALT_BIT] ? S_DONE : S_ISSUE;
            S_ISSUE: begin
                if (beat && (rep_cnt == 4'd0)) begin
                    state_nxt = last_inst ? S_DONE : S_FETCH;
                end
            end
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rd_en      = (state == S_FETCH);
        rd_addr    = pc;
        inst_valid = (state == S_ISSUE);
        busy       = (state == S_FETCH) || (state == S_CAPTURE) || (state == S_ISSUE);
        done       = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= '0;
            count_q  <= '0;
            rep_cnt  <= '0;
            inst_out <= '0;
            mem_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ex) begin
                        count_q  <= inst_count;
                        mem_addr <= mem_base;
                        pc       <= '0;
                    end
                end
                S_CAPTURE: begin
                    inst_out <= rd_data;
                    rep_cnt  <= rd_data[REP_HI -: 4];
                end
                S_ISSUE: begin
                    if (beat) begin
                        mem_addr <= mem_addr + {{(MEM_AW-1){1'b0}}, 1'b1};
                        if (rep_cnt != 4'd0) begin
                            rep_cnt <= rep_cnt - 4'd1;
                        end else begin
                            pc <= pc + {{(DEPTH_LOG-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/inst_sequencer.md
Name: inst_sequencer

Overview:
- Execution-side consumer of the loaded instruction memory.
- After start_ex, walks the buffer from address 0 and issues each 17-bit instruction to the dual-core array with a valid/ready handshake.
- Expands per-instruction repeat counts and generates the activation-memory read address in step with each accepted beat.
- Reports busy/done to the top-level controller.

Parameters:
- INST_BW, 17, instruction word width.
- DEPTH_LOG, 4, instruction memory address width (16 entries).
- MEM_AW, 6, activation memory address width.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start_ex  input  1  begin execution; sampled only in IDLE.
- inst_count  input  DEPTH_LOG+1  number of valid loaded instructions, 0..16; sampled at start.
- mem_base  input  MEM_AW  starting activation address; sampled at start.
- rd_en  output  1  instruction memory read strobe.
- rd_addr  output  DEPTH_LOG  instruction memory read address.
- rd_data  input  INST_BW  read data, valid exactly one cycle after rd_en.
- inst_out  output  INST_BW  instruction presented to the core.
- inst_valid  output  1  inst_out valid.
- core_ready  input  1  core accepts inst_out this cycle.
- mem_addr  output  MEM_AW  activation read address for the current beat.
- busy  output  1  high in FETCH, CAPTURE and ISSUE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0, asynchronous) forces state=IDLE, pc=0, rep_cnt=0, rd_en=0, rd_addr=0, inst_out=0, inst_valid=0, mem_addr=0, busy=0, done=0.
- Instruction fields:
  - bit16 = HALT.
  - bits15:12 = R; the instruction is issued R+1 times.
  - inst_out always carries the full 17-bit word unchanged.
- IDLE, start_ex=1:
  - Latch inst_count and mem_base; pc=0; mem_addr=mem_base.
  - If inst_count==0, go to DONE; otherwise go to FETCH.
- FETCH: rd_en=1, rd_addr=pc for exactly one cycle, then CAPTURE.
- CAPTURE:
  - Register rd_data into inst_out and set rep_cnt=R.
  - If HALT=1, go to DONE with no issue; otherwise go to ISSUE.
- ISSUE:
  - inst_valid=1 and inst_out is held stable while core_ready=0.
  - A beat completes on the edge where inst_valid&core_ready.
  - On each completed beat, mem_addr increments by 1 and wraps modulo 2^MEM_AW.
  - rep_cnt>0: decrement, stay in ISSUE (back-to-back beats, no bubble).
  - rep_cnt==0: inst_valid drops next cycle and pc increments. If pc+1==inst_count (including 16, the full buffer), go to DONE; otherwise go to FETCH.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Latency:
  - start_ex sampled at edge 0 gives the first inst_valid after edge 2 (visible cycle 3).
  - Per-instruction overhead is 2 bubble cycles (FETCH + CAPTURE).
- Boundaries:
  - start_ex while busy is ignored; the latched inst_count/mem_base do not change.
  - start_ex in the DONE cycle is ignored.
  - pc never addresses beyond inst_count-1; rd_addr wraps naturally at 16 only on the terminating increment, and no read is issued there.
  - core_ready held low indefinitely means the sequencer stalls in ISSUE with no timeout.
  - Reset asserted mid-operation aborts immediately; no done pulse is produced. After release the block is in IDLE and needs a fresh start_ex.

Test Plan:
1. inst_count=3, words 0x00011, 0x01022, 0x00033, mem_base=5, core_ready=1 -> inst_out sequence 0x00011, 0x01022, 0x01022, 0x00033. mem_addr=5,6,7,8 on the beats. done pulses once. busy falls together with the done pulse.
2. inst_count=2, word0=0x10000 (HALT) -> no inst_valid ever asserted, single rd_en at addr 0, done pulse 3 cycles after start.
3. inst_count=1, word 0x0F0AA, mem_base=60, MEM_AW=6, core_ready toggling 1,0,1,0 -> 16 accepted beats. mem_addr wraps 63->0. inst_out stays stable while core_ready=0. done pulses after the 16th beat.
4. inst_count=0, start_ex -> done pulse in the next cycle, rd_en never asserted.
5. Drive start_ex again while busy, then assert reset mid-ISSUE (the instruction has repeats remaining) -> the second start is ignored. On reset all outputs clear asynchronously, there is no done pulse, and after release inst_valid stays 0 until a new start_ex.
6. inst_count=16, all words 0x00001 -> rd_addr sweeps 0..15 with 16 beats. done pulses. No read is issued at rd_addr 0 after the wrap.
